// File: rtl/cpout_pkg.sv
// cpout_pkg: panel protocol constants shared by the command interpreter and
// the lamp-state output serializer (tags, lamp bit positions, frame length).
package cpout_pkg;

    // Frame geometry
    localparam int         CP_FRAME_LEN = 7;
    localparam logic [2:0] CP_LAST_IDX  = 3'(CP_FRAME_LEN - 1);

    // Byte tags; the sync byte carries no payload
    localparam logic [7:0] CP_SYNC         = 8'h00;
    localparam logic [1:0] CP_TAG_W_LO     = 2'b01;
    localparam logic [2:0] CP_TAG_W_MID    = 3'b100;
    localparam logic [2:0] CP_TAG_W_HI     = 3'b101;
    localparam logic [2:0] CP_TAG_LAMP_LO  = 3'b110;
    localparam logic [2:0] CP_TAG_LAMP_HI  = 3'b001;
    localparam logic [2:0] CP_TAG_ROT      = 3'b111;

    // Status lamp bit positions
    localparam int LAMP_W     = 10;
    localparam int LAMP_P     = 0;
    localparam int LAMP_MC    = 1;
    localparam int LAMP_Q     = 2;
    localparam int LAMP_STOP  = 3;
    localparam int LAMP_WAIT  = 4;
    localparam int LAMP_ALARM = 5;
    localparam int LAMP_IRQ   = 6;
    localparam int LAMP_CLOCK = 7;
    localparam int LAMP_MODE  = 8;
    localparam int LAMP_AUX   = 9;

    // Serializer FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Panel state captured at frame start
    typedef struct packed {
        logic [15:0]       w;
        logic [LAMP_W-1:0] lamps;
        logic [3:0]        rot;
    } cp_snap_t;

endpackage

// File: rtl/cpout_if.sv
// cpout_if: request side (panel lamp logic) plus UART TX handshake.
// master = the surrounding system (lamp logic and UART), slave = cpout.
interface cpout_if;
    import cpout_pkg::*;

    logic              send_leds;
    logic [15:0]       w;
    logic [LAMP_W-1:0] lamps;
    logic [3:0]        rotary_pos;
    logic              tx_busy;
    logic [7:0]        tx_byte;
    logic              tx_send;
    logic              busy;

    modport master (
        output send_leds, w, lamps, rotary_pos, tx_busy,
        input  tx_byte, tx_send, busy
    );

    modport slave (
        input  send_leds, w, lamps, rotary_pos, tx_busy,
        output tx_byte, tx_send, busy
    );

endinterface

// File: rtl/cpout_frame.sv
// cpout_frame: selects the tagged frame byte for a given position from the
// captured panel state. Purely combinational.
module cpout_frame
    import cpout_pkg::*;
(
    input  logic [2:0] idx,
    input  cp_snap_t   snap,
    output logic [7:0] frame_byte
);

    // Byte mux over the fixed frame layout; unreachable idx 7 maps to sync
    always_comb begin
        frame_byte = CP_SYNC;
        case (idx)
            3'd0:    frame_byte = CP_SYNC;
            3'd1:    frame_byte = {CP_TAG_W_LO,    snap.w[5:0]};
            3'd2:    frame_byte = {CP_TAG_W_MID,   snap.w[10:6]};
            3'd3:    frame_byte = {CP_TAG_W_HI,    snap.w[15:11]};
            3'd4:    frame_byte = {CP_TAG_LAMP_LO, snap.lamps[LAMP_WAIT:LAMP_P]};
            3'd5:    frame_byte = {CP_TAG_LAMP_HI, snap.lamps[LAMP_AUX:LAMP_ALARM]};
            3'd6:    frame_byte = {CP_TAG_ROT,     1'b0, snap.rot};
            default: frame_byte = CP_SYNC;
        endcase
    end

endmodule

// File: rtl/cpout.sv
// cpout: control-panel output serializer. Snapshots lamp state on request and
// streams the 7-byte frame to the UART TX over a strobe/busy handshake.
module cpout
    import cpout_pkg::*;
(
    input  logic clk_sys,
    input  logic rst_n,
    cpout_if.slave cp
);

    logic [1:0] state_q,   state_d;
    logic [2:0] idx_q,     idx_d;
    logic       pending_q, pending_d;
    cp_snap_t   snap_q,    snap_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_send_q, tx_send_d;
    logic [7:0] frame_byte;

    cpout_frame u_frame (
        .idx        (idx_q),
        .snap       (snap_q),
        .frame_byte (frame_byte)
    );

    // Next-state: frame sequencing, handshake and request collapsing
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        tx_byte_d = tx_byte_q;
        tx_send_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cp.send_leds || pending_q) begin
                    snap_d.w     = cp.w;
                    snap_d.lamps = cp.lamps;
                    snap_d.rot   = cp.rotary_pos;
                    pending_d    = 1'b0;
                    idx_d        = 3'd0;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_byte_d = frame_byte;
                tx_send_d = 1'b1;
                state_d   = ST_WAIT_BUSY;
            end
            // Wait for the UART to acknowledge by raising busy (level, not edge)
            ST_WAIT_BUSY: begin
                if (cp.tx_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!cp.tx_busy) begin
                    if (idx_q == CP_LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests arriving mid-frame fold into a single follow-up frame,
        // including one that lands on the cycle the last byte completes
        if (cp.send_leds && (state_q != ST_IDLE)) pending_d = 1'b1;
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            tx_byte_q <= 8'h00;
            tx_send_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            tx_byte_q <= tx_byte_d;
            tx_send_q <= tx_send_d;
        end
    end

    assign cp.tx_byte = tx_byte_q;
    assign cp.tx_send = tx_send_q;
    assign cp.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpout.sv
// tb_cpout: table-driven frames, hand-written handshake corner cases and a
// randomized run scored against a byte-level frame model and a UART TX model.
module tb_cpout;
    import cpout_pkg::*;

    typedef struct {
        logic [15:0] w;
        logic [9:0]  lamps;
        logic [3:0]  rot;
        logic [55:0] exp;   // B0 in the top byte
    } vec_t;

    logic clk_sys = 1'b0;
    logic rst_n;
    cpout_if dif();

    cpout dut (.clk_sys(clk_sys), .rst_n(rst_n), .cp(dif));

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int rx_cnt = 0;
    int pos = 0;
    int last_fall = 0;
    int strobe_cyc = 0;
    int b0_gap = 0;
    int busy_fall_cyc = 0;
    bit rand_tx = 1'b0;
    int tx_dly = 0;
    int tx_hold = 3;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame model written from the byte layout with plain arithmetic
    task automatic push_frame(input logic [15:0] w, input logic [9:0] l, input logic [3:0] r);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h40 + 8'(w % 64));
        exp_q.push_back(8'h80 + 8'((w / 64) % 32));
        exp_q.push_back(8'hA0 + 8'((w / 2048) % 32));
        exp_q.push_back(8'hC0 + 8'(l % 32));
        exp_q.push_back(8'h20 + 8'((l / 32) % 32));
        exp_q.push_back(8'hE0 + 8'(r));
    endtask

    // UART TX model: accepts a strobe, optionally delays, holds busy, drops it
    initial begin
        dif.tx_busy = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (dif.tx_send === 1'b1) begin
                int d;
                int h;
                logic [7:0] e;
                strobe_cyc = cyc;
                rx_cnt++;
                if (pos != 0) chk("inter_byte_gap", cyc - last_fall, 2);
                else b0_gap = cyc - last_fall;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %02h, expected no byte", dif.tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", dif.tx_byte, e);
                end
                pos = (pos == 6) ? 0 : pos + 1;
                d = rand_tx ? int'($urandom_range(2, 0)) : tx_dly;
                h = rand_tx ? int'($urandom_range(6, 1)) : tx_hold;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk_sys);
                    chk("repeat_strobe", dif.tx_send, 0);
                end
                dif.tx_busy = 1'b1;
                for (int i = 0; i < h; i++) begin
                    @(negedge clk_sys);
                    chk("strobe_while_busy", dif.tx_send, 0);
                end
                dif.tx_busy = 1'b0;
                last_fall = cyc;
            end
        end
    end

    // Record when busy drops
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (prev && !dif.busy) busy_fall_cyc = cyc;
            prev = dif.busy;
        end
    end

    // Pulse a request from idle; check acceptance and first-strobe latency
    task automatic request_frame();
        dif.send_leds = 1'b1;
        @(negedge clk_sys);
        dif.send_leds = 1'b0;
        chk("accept_busy", dif.busy, 1);
        chk("accept_no_strobe", dif.tx_send, 0);
        dif.w          = ~dif.w;
        dif.lamps      = ~dif.lamps;
        dif.rotary_pos = ~dif.rotary_pos;
        @(negedge clk_sys);
        chk("first_strobe_latency", dif.tx_send, 1);
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (rx_cnt < target) begin
            checks++; errors++;
            $display("FAIL rx_timeout: got %0d bytes, expected %0d", rx_cnt, target);
        end
    endtask

    task automatic wait_drain(input int budget, input int settle);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (settle) @(negedge clk_sys);
        chk("idle_after_frame", dif.busy, 0);
    endtask

    task automatic set_inputs(input logic [15:0] w, input logic [9:0] l, input logic [3:0] r);
        dif.w = w; dif.lamps = l; dif.rotary_pos = r;
    endtask

    initial begin
        vec_t tbl[5];
        int   base;
        int   s;
        logic [15:0] w2;
        logic [9:0]  l2;
        logic [3:0]  r2;

        tbl[0] = '{w:16'hA5C3, lamps:10'h2B5, rot:4'd9, exp:56'h00_43_97_B4_D5_35_E9};
        tbl[1] = '{w:16'h0000, lamps:10'h000, rot:4'd0, exp:56'h00_40_80_A0_C0_20_E0};
        tbl[2] = '{w:16'hFFFF, lamps:10'h3FF, rot:4'hF, exp:56'h00_7F_9F_BF_DF_3F_EF};
        tbl[3] = '{w:16'h0840, lamps:10'h021, rot:4'd1, exp:56'h00_40_81_A1_C1_21_E1};
        tbl[4] = '{w:16'h8420, lamps:10'h210, rot:4'd8, exp:56'h00_60_90_B0_D0_30_E8};

        dif.send_leds = 1'b0;
        set_inputs(16'h0, 10'h0, 4'h0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset_tx_byte", dif.tx_byte, 0);
        chk("reset_tx_send", dif.tx_send, 0);
        chk("reset_busy", dif.busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Directed frames; inputs are inverted right after acceptance
        for (int i = 0; i < 5; i++) begin
            set_inputs(tbl[i].w, tbl[i].lamps, tbl[i].rot);
            for (int j = 0; j < 7; j++) exp_q.push_back(tbl[i].exp[55 - 8*j -: 8]);
            request_frame();
            wait_drain(500, 12);
            chk("busy_fall_after_tx_busy", busy_fall_cyc - last_fall, 1);
        end

        // Three requests mid-frame collapse into exactly one follow-up
        base = rx_cnt;
        set_inputs(16'h1234, 10'h155, 4'd3);
        push_frame(16'h1234, 10'h155, 4'd3);
        request_frame();
        wait_rx(base + 2, 200);
        set_inputs(16'hBEEF, 10'h0AA, 4'd12);
        push_frame(16'hBEEF, 10'h0AA, 4'd12);
        for (int p = 0; p < 3; p++) begin
            dif.send_leds = 1'b1;
            @(negedge clk_sys);
            dif.send_leds = 1'b0;
            @(negedge clk_sys);
        end
        wait_drain(500, 20);
        chk("collapsed_byte_count", rx_cnt - base, 14);
        chk("followup_b0_gap", b0_gap, 3);

        // Request coincident with the final tx_busy fall of a frame
        tx_hold = 4;
        base = rx_cnt;
        set_inputs(16'h0F0F, 10'h3C3, 4'd5);
        push_frame(16'h0F0F, 10'h3C3, 4'd5);
        request_frame();
        wait_rx(base + 7, 300);
        s = strobe_cyc;
        while (cyc < s + 4) @(negedge clk_sys);
        set_inputs(16'h7001, 10'h111, 4'd14);
        push_frame(16'h7001, 10'h111, 4'd14);
        dif.send_leds = 1'b1;
        @(negedge clk_sys);
        dif.send_leds = 1'b0;
        wait_drain(500, 20);
        chk("coincident_byte_count", rx_cnt - base, 14);
        chk("coincident_b0_gap", b0_gap, 3);

        // Slow UART: busy held 100 cycles per byte
        tx_hold = 100;
        base = rx_cnt;
        set_inputs(16'hC001, 10'h201, 4'd7);
        push_frame(16'hC001, 10'h201, 4'd7);
        request_frame();
        wait_drain(2000, 110);
        chk("slow_byte_count", rx_cnt - base, 7);

        // Reset asserted on the B3 strobe with a follow-up request pending
        tx_hold = 3;
        base = rx_cnt;
        set_inputs(16'h5A5A, 10'h0F0, 4'd2);
        push_frame(16'h5A5A, 10'h0F0, 4'd2);
        request_frame();
        wait_rx(base + 3, 200);
        dif.send_leds = 1'b1;
        @(negedge clk_sys);
        dif.send_leds = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk_sys);
                n++;
            end while (dif.tx_send !== 1'b1 && n < 100);
        end
        chk("strobe_before_reset", dif.tx_send, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_send", dif.tx_send, 0);
        chk("abort_busy", dif.busy, 0);
        chk("abort_tx_byte", dif.tx_byte, 0);
        exp_q.delete();
        base = rx_cnt;
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (60) @(negedge clk_sys);
        chk("no_bytes_after_abort", rx_cnt - base, 0);
        chk("idle_after_abort", dif.busy, 0);
        pos = 0;

        // Randomized frames, random UART timing, random mid-frame re-requests
        rand_tx = 1'b1;
        for (int it = 0; it < 20; it++) begin
            base = rx_cnt;
            w2 = 16'($urandom); l2 = 10'($urandom); r2 = 4'($urandom);
            set_inputs(w2, l2, r2);
            push_frame(w2, l2, r2);
            request_frame();
            if ($urandom_range(1, 0) == 1) begin
                int np;
                wait_rx(base + int'($urandom_range(5, 1)), 200);
                w2 = 16'($urandom); l2 = 10'($urandom); r2 = 4'($urandom);
                set_inputs(w2, l2, r2);
                push_frame(w2, l2, r2);
                np = int'($urandom_range(3, 1));
                for (int p = 0; p < np; p++) begin
                    dif.send_leds = 1'b1;
                    @(negedge clk_sys);
                    dif.send_leds = 1'b0;
                    @(negedge clk_sys);
                end
            end
            wait_drain(2000, 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
